// File: rtl/jkc_pkg.sv
// ============================================================
// Package : jkc_pkg
// Brief   : JK encodings, steering modes and defaults for jk_sync_counter.
// Rev     : 1.0 - initial release
// ============================================================
`default_nettype none

package jkc_pkg;

  // {j,k} encodings
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam int JKC_DEF_WIDTH   = 4;
  localparam int JKC_DEF_MODULUS = 10;

  typedef enum logic [2:0] {
    MODE_HOLD    = 3'd0,
    MODE_UP      = 3'd1,
    MODE_DOWN    = 3'd2,
    MODE_WRAP_UP = 3'd3,
    MODE_WRAP_DN = 3'd4,
    MODE_LOAD    = 3'd5
  } jkc_mode_e;

  function automatic logic [1:0] jk_force(input logic b);
    return b ? JK_SET : JK_RESET;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// ============================================================
// Module : jk_cell
// Brief  : Single JK flip-flop with synchronous active-high reset.
// Rev    : 1.0 - initial release
// ============================================================
`default_nettype none

module jk_cell
  import jkc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else begin
      case ({j, k})
        JK_RESET:  r_q <= 1'b0;
        JK_SET:    r_q <= 1'b1;
        JK_TOGGLE: r_q <= ~r_q;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/jk_sync_counter.sv
// ============================================================
// Module : jk_sync_counter
// Brief  : Modulo up/down counter built from JK cells; only j/k steering,
//          tc and wrap live here. Optional parallel load: JKC_LOAD_EN.
// Rev    : 1.0 - initial release
// ============================================================
`default_nettype none

module jk_sync_counter
  import jkc_pkg::*;
#(
  parameter int WIDTH   = JKC_DEF_WIDTH,
  parameter int MODULUS = JKC_DEF_MODULUS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
`ifdef JKC_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   c_MOD_EXT = (WIDTH + 1)'(MODULUS);

  jkc_mode_e              w_mode;
  logic [WIDTH-1:0]       w_tog_up;
  logic [WIDTH-1:0]       w_tog_dn;
  logic [WIDTH-1:0][1:0]  w_jk;
  logic                   w_at_max;
  logic                   w_at_zero;
  logic                   r_wrap;

  assign w_at_max  = (count == c_MAX);
  assign w_at_zero = (count == '0);

`ifdef JKC_LOAD_EN
  logic [WIDTH-1:0] w_load_val;
  // Out-of-range load values saturate to the top of the count range
  assign w_load_val = ({1'b0, din} >= c_MOD_EXT) ? c_MAX : din;
`endif

  always_comb begin
    w_mode = MODE_HOLD;
`ifdef JKC_LOAD_EN
    if (load) w_mode = MODE_LOAD;
    else
`endif
    if (en) begin
      if (up) w_mode = w_at_max  ? MODE_WRAP_UP : MODE_UP;
      else    w_mode = w_at_zero ? MODE_WRAP_DN : MODE_DOWN;
    end
  end

  // Ripple-free toggle conditions: all lower bits 1 (up) or all 0 (down)
  for (genvar i = 0; i < WIDTH; i++) begin : g_tog
    if (i == 0) begin : g_lsb
      assign w_tog_up[i] = 1'b1;
      assign w_tog_dn[i] = 1'b1;
    end else begin : g_upper
      assign w_tog_up[i] = &count[i-1:0];
      assign w_tog_dn[i] = ~|count[i-1:0];
    end
  end

  always_comb begin
    w_jk = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (w_mode)
        MODE_UP:      w_jk[i] = w_tog_up[i] ? JK_TOGGLE : JK_HOLD;
        MODE_DOWN:    w_jk[i] = w_tog_dn[i] ? JK_TOGGLE : JK_HOLD;
        MODE_WRAP_UP: w_jk[i] = JK_RESET;
        MODE_WRAP_DN: w_jk[i] = jk_force(c_MAX[i]);
`ifdef JKC_LOAD_EN
        MODE_LOAD:    w_jk[i] = jk_force(w_load_val[i]);
`endif
        default:      w_jk[i] = JK_HOLD;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (w_jk[i][1]),
      .k     (w_jk[i][0]),
      .q     (count[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) r_wrap <= 1'b0;
    else       r_wrap <= (w_mode == MODE_WRAP_UP) || (w_mode == MODE_WRAP_DN);
  end

  assign tc   = en & ((up & w_at_max) | (~up & w_at_zero));
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_jk_sync_counter.sv
// Bench for jk_sync_counter: directed sequences with literal expectations
// plus randomized stimulus against a modulo-arithmetic model.
`default_nettype none

module tb_jk_sync_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset, en, up, load;
  logic [W-1:0] din;
  logic [W-1:0] count;
  logic         tc, wrap;

  int checks = 0;
  int errors = 0;

  int m_count = 0;
  bit m_wrap  = 1'b0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  jk_sync_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .up    (up),
`ifdef JKC_LOAD_EN
    .load  (load),
    .din   (din),
`endif
    .count (count),
    .tc    (tc),
    .wrap  (wrap)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain modulo arithmetic on an integer
  always @(posedge clk) begin
    m_wrap = 1'b0;
    if (reset) begin
      m_count = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (load) begin
        m_count = (int'(din) >= M) ? M - 1 : int'(din);
      end else if (en) begin
        if (up) begin
          m_wrap  = (m_count == M - 1);
          m_count = (m_count + 1) % M;
        end else begin
          m_wrap  = (m_count == 0);
          m_count = (m_count + M - 1) % M;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_count", int'(count), m_count);
      chk("model_wrap", int'(wrap), int'(m_wrap));
      chk("model_tc", int'(tc),
          int'(en && ((up && m_count == M - 1) || (!up && m_count == 0))));
      chk("range", int'(int'(count) < M), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq[12];
    exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = '0;
    tick();
    tick();
    chk("reset_count", int'(count), 0);
    chk("reset_wrap", int'(wrap), 0);

    // Count up through a full wrap
    reset = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("up_seq_count", int'(count), exp_seq[k]);
      chk("up_seq_wrap", int'(wrap), int'(exp_seq[k] == 0));
      chk("up_seq_tc", int'(tc), int'(exp_seq[k] == 9));
    end

    // Down from zero wraps to 9
    reset = 1'b1; tick();
    reset = 1'b0; up = 1'b0;
    tick(); chk("dn_wrap_count", int'(count), 9); chk("dn_wrap_pulse", int'(wrap), 1);
    tick(); chk("dn_8", int'(count), 8); chk("dn_8_wrap", int'(wrap), 0);
    tick(); chk("dn_7", int'(count), 7);
    tick(); tick(); chk("dn_5", int'(count), 5);

    // Hold with direction toggling
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      up = ~up;
      tick();
      chk("hold_count", int'(count), 5);
      chk("hold_tc", int'(tc), 0);
      chk("hold_wrap", int'(wrap), 0);
    end

    // Reset wins over a pending wrap
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_reset_9", int'(count), 9);
    reset = 1'b1; tick();
    chk("reset_over_wrap_count", int'(count), 0);
    chk("reset_over_wrap_pulse", int'(wrap), 0);
    reset = 1'b0;

`ifdef JKC_LOAD_EN
    load = 1'b1; din = 4'd7; en = 1'b1;
    tick(); chk("load7_count", int'(count), 7); chk("load7_wrap", int'(wrap), 0);
    din = 4'd12;
    tick(); chk("load12_count", int'(count), 9); chk("load12_wrap", int'(wrap), 0);
    din = 4'd3; up = 1'b1;
    tick(); chk("load_over_en", int'(count), 3);
    load = 1'b0;
`endif

    // Randomized run
    for (int n = 0; n < 10000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      en    = $urandom_range(0, 3) != 0;
      up    = $urandom_range(0, 1) == 1;
`ifdef JKC_LOAD_EN
      load  = ($urandom_range(0, 7) == 0);
      din   = W'($urandom_range(0, 15));
`endif
      tick();
    end

    reset = 1'b0; en = 1'b0; load = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
